sm83_int_ctl: RTL and testbench
===============================

Name: sm83_int_ctl

Overview:
- Interrupt controller and sequencer for the sm83 core.
- Arbitrates the `irq` request lines and tracks the interrupt master enable (IME), including the one-instruction EI delay.
- Sequences HALT, HALT-bug and the 5-M-cycle interrupt dispatch, and tells the control unit when to replace the next opcode fetch with a dispatch.
- Produces the restart vector and the one-hot `iack` used to clear the serviced request.

Parameters:
- NUM_IRQS, 8, number of request lines; index 0 has the highest priority.
- VEC_BASE, 8'h40, low byte of the vector for irq 0; vector(n) = VEC_BASE + 8*n, modulo 256.
- DISP_CYCLES, 5, M-cycles per dispatch.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- t4  in  1  last T-state of the current M-cycle; all state changes happen on clk edges where t4=1.
- irq  in  NUM_IRQS  pending-and-enabled requests (IF & IE), level.
- instr_end  in  1  current M-cycle is the last of an instruction.
- ctl_ei  in  1  EI executing (valid with instr_end).
- ctl_di  in  1  DI executing (valid with instr_end).
- ctl_reti  in  1  RETI executing (valid with instr_end).
- ctl_halt  in  1  HALT executing (valid with instr_end).
- iack  out  NUM_IRQS  one-hot acknowledge of the serviced request.
- int_dispatch  out  1  dispatch sequence is active.
- disp_m  out  3  dispatch M-cycle index, 0..4.
- vector  out  8  low byte of the restart address; the high byte is always 0.
- halted  out  1  core is in HALT.
- halt_bug  out  1  next opcode fetch must not increment PC.
- ime  out  1  interrupt master enable.

Behaviour:
- Reset (synchronous, wins over everything):
  - Forces state RUN.
  - Clears ime, ime_pend, iack, int_dispatch, disp_m, vector, halted, halt_bug.
  - Asserting reset in the middle of a dispatch or HALT aborts it.
- Effective enable: ime_eff = (ime | ime_pend | ctl_reti) & ~ctl_di.
- take = instr_end & ime_eff & |irq.
- States: RUN, HALT, DISPATCH. All transitions occur on t4 edges.
- RUN, on a t4 edge with instr_end:
  - ctl_di clears ime and ime_pend.
  - ctl_reti sets ime.
  - ctl_ei sets ime_pend only.
  - Otherwise an ime_pend already set is promoted to ime. The instruction after EI therefore completes before any interrupt is taken.
  - If take: go to DISPATCH, disp_m=0, and clear ime and ime_pend.
  - Else if ctl_halt and |irq and !ime_eff: stay in RUN and pulse halt_bug for the next M-cycle only.
  - Else if ctl_halt: go to HALT.
- HALT:
  - halted=1.
  - On a t4 edge with |irq: go to DISPATCH if ime=1 (clearing ime), otherwise go to RUN.
  - halted drops on the same edge.
- DISPATCH:
  - int_dispatch=1; disp_m increments on each t4 edge.
  - Cycles 0-1: internal. Cycle 2: push PC high byte. Cycle 3: push PC low byte. Cycle 4: PC load.
  - At the t4 edge ending cycle 2, irq is sampled (after any IE write made by the high-byte push).
    - The lowest set index n is chosen; vector = VEC_BASE + 8*n and iack = onehot(n).
    - If irq=0 at that edge: vector = 8'h00 and iack stays 0.
  - iack is high for exactly cycle 3 (one M-cycle).
  - vector is held until the next sample.
  - The t4 edge ending cycle 4 returns to RUN with disp_m=0.
  - instr_end, ctl_ei, ctl_di, ctl_reti and ctl_halt are ignored during DISPATCH.
- Edges without t4 change nothing.
- Simultaneous inputs:
  - ctl_di together with ctl_ei: DI wins.
  - irq changing during cycles 0-1 is irrelevant; only the cycle-2 sample matters.

Decomposition:
- Shared package sm83_pkg holds:
  - word_t and irq_t;
  - NUM_IRQS and VEC_BASE;
  - the enum int_state_t {RUN, HALT, DISPATCH}.
- One natural sub-module: sm83_irq_prio, a combinational lowest-index priority encoder.
  - Inputs: irq.
  - Outputs: valid, index, onehot.

Test Plan:
- irq=8'h04, ime=1, instr_end -> DISPATCH; disp_m steps 0..4 over 5 M-cycles; vector=8'h50; iack=8'h04 during cycle 3 only; ime=0 afterwards.
- EI, then NOP, with irq=8'h01 held -> no dispatch at EI's end; dispatch at NOP's end; vector=8'h40.
- irq=8'h03 at the cycle-2 sample -> iack=8'h01, vector=8'h40. irq dropped to 0 before the cycle-2 sample -> vector=8'h00, iack=0.
- ime=0, irq=0, HALT -> halted=1. Raise irq=8'h10 -> halted=0 and back to RUN next M-cycle, no dispatch. Repeat with ime=1 -> DISPATCH, vector=8'h60.
- ime=0, irq=8'h02 pending, HALT -> no halt; halt_bug=1 for exactly one M-cycle.
- Reset during disp_m=3 -> next cycle: RUN, iack=0, int_dispatch=0, ime=0.
- DI together with irq pending while ime=1 -> no dispatch; ime=0.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 interrupt controller slice.
package sm83_pkg;

    localparam int NUM_IRQS    = 8;
    localparam int IDX_W       = $clog2(NUM_IRQS);
    localparam int DISP_CYCLES = 5;
    localparam logic [7:0] VEC_BASE = 8'h40;

    typedef logic [7:0]          word_t;
    typedef logic [NUM_IRQS-1:0] irq_t;
    typedef logic [IDX_W-1:0]    idx_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALT     = 2'd1,
        DISPATCH = 2'd2
    } int_state_t;

    // Restart vector low byte for request n; wraps modulo 256.
    function automatic word_t vec_of(input idx_t n);
        vec_of = VEC_BASE + word_t'({n, 3'b000});
    endfunction

endpackage

// File: rtl/sm83_int_ctl_if.sv
// Control-unit side of the interrupt controller: request/instruction inputs and dispatch outputs.
interface sm83_int_ctl_if;
    import sm83_pkg::*;

    logic        t4;
    irq_t        irq;
    logic        instr_end;
    logic        ctl_ei;
    logic        ctl_di;
    logic        ctl_reti;
    logic        ctl_halt;
    irq_t        iack;
    logic        int_dispatch;
    logic [2:0]  disp_m;
    word_t       vector;
    logic        halted;
    logic        halt_bug;
    logic        ime;

    modport master (
        output t4, irq, instr_end, ctl_ei, ctl_di, ctl_reti, ctl_halt,
        input  iack, int_dispatch, disp_m, vector, halted, halt_bug, ime
    );

    modport slave (
        input  t4, irq, instr_end, ctl_ei, ctl_di, ctl_reti, ctl_halt,
        output iack, int_dispatch, disp_m, vector, halted, halt_bug, ime
    );

endinterface

// File: rtl/sm83_irq_prio.sv
// Combinational lowest-index-wins priority encoder over the request lines.
module sm83_irq_prio
    import sm83_pkg::*;
(
    input  irq_t irq,
    output logic valid,
    output idx_t index,
    output irq_t onehot
);

    // Isolate the lowest set bit, then encode its position.
    always_comb begin
        valid  = |irq;
        onehot = irq & (~irq + irq_t'(1'b1));
        index  = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_IRQS; i++) begin
            index = index | (onehot[i] ? idx_t'(i) : {IDX_W{1'b0}});
        end
    end

endmodule

// File: rtl/sm83_int_ctl.sv
// Interrupt sequencer: IME/EI delay tracking, HALT and HALT-bug handling, 5 M-cycle dispatch.
module sm83_int_ctl
    import sm83_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    sm83_int_ctl_if.slave bus
);

    localparam logic [2:0] DISP_SAMPLE = 3'd2;
    localparam logic [2:0] DISP_LAST   = 3'(DISP_CYCLES - 1);

    int_state_t  state_q, state_d;
    logic        ime_q, ime_d;
    logic        ime_pend_q, ime_pend_d;
    irq_t        iack_q, iack_d;
    logic        int_dispatch_q, int_dispatch_d;
    logic [2:0]  disp_m_q, disp_m_d;
    word_t       vector_q, vector_d;
    logic        halted_q, halted_d;
    logic        halt_bug_q, halt_bug_d;

    logic        prio_valid;
    idx_t        prio_index;
    irq_t        prio_onehot;
    logic        ime_eff;
    logic        take;

    sm83_irq_prio u_prio (
        .irq    (bus.irq),
        .valid  (prio_valid),
        .index  (prio_index),
        .onehot (prio_onehot)
    );

    assign ime_eff = (ime_q | ime_pend_q | bus.ctl_reti) & ~bus.ctl_di;
    assign take    = bus.instr_end & ime_eff & prio_valid;

    // Next-state and output computation; only t4 edges advance anything.
    always_comb begin
        state_d        = state_q;
        ime_d          = ime_q;
        ime_pend_d     = ime_pend_q;
        iack_d         = iack_q;
        int_dispatch_d = int_dispatch_q;
        disp_m_d       = disp_m_q;
        vector_d       = vector_q;
        halted_d       = halted_q;
        halt_bug_d     = halt_bug_q;
        if (bus.t4) begin
            halt_bug_d = 1'b0;
            case (state_q)
                RUN: begin
                    if (bus.instr_end) begin
                        if (bus.ctl_di) begin
                            ime_d      = 1'b0;
                            ime_pend_d = 1'b0;
                        end else if (bus.ctl_reti) begin
                            ime_d = 1'b1;
                        end else if (bus.ctl_ei) begin
                            ime_pend_d = 1'b1;
                        end else if (ime_pend_q) begin
                            ime_d      = 1'b1;
                            ime_pend_d = 1'b0;
                        end else begin
                            ime_d = ime_q;
                        end
                        if (take) begin
                            state_d        = DISPATCH;
                            int_dispatch_d = 1'b1;
                            disp_m_d       = 3'd0;
                            ime_d          = 1'b0;
                            ime_pend_d     = 1'b0;
                        end else if (bus.ctl_halt && prio_valid && !ime_eff) begin
                            halt_bug_d = 1'b1;
                        end else if (bus.ctl_halt) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                HALT: begin
                    if (prio_valid) begin
                        halted_d = 1'b0;
                        if (ime_q) begin
                            state_d        = DISPATCH;
                            int_dispatch_d = 1'b1;
                            disp_m_d       = 3'd0;
                            ime_d          = 1'b0;
                            ime_pend_d     = 1'b0;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = HALT;
                    end
                end
                DISPATCH: begin
                    // The sample follows the high-byte push so an IE write there is honoured.
                    if (disp_m_q == DISP_SAMPLE) begin
                        vector_d = prio_valid ? vec_of(prio_index) : 8'h00;
                        iack_d   = prio_onehot;
                    end else begin
                        iack_d = {NUM_IRQS{1'b0}};
                    end
                    if (disp_m_q == DISP_LAST) begin
                        state_d        = RUN;
                        int_dispatch_d = 1'b0;
                        disp_m_d       = 3'd0;
                    end else begin
                        disp_m_d = disp_m_q + 3'd1;
                    end
                end
                default: begin
                    state_d        = RUN;
                    int_dispatch_d = 1'b0;
                    disp_m_d       = 3'd0;
                    iack_d         = {NUM_IRQS{1'b0}};
                    halted_d       = 1'b0;
                end
            endcase
        end else begin
            halt_bug_d = halt_bug_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            ime_q          <= 1'b0;
            ime_pend_q     <= 1'b0;
            iack_q         <= {NUM_IRQS{1'b0}};
            int_dispatch_q <= 1'b0;
            disp_m_q       <= 3'd0;
            vector_q       <= 8'h00;
            halted_q       <= 1'b0;
            halt_bug_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ime_q          <= ime_d;
            ime_pend_q     <= ime_pend_d;
            iack_q         <= iack_d;
            int_dispatch_q <= int_dispatch_d;
            disp_m_q       <= disp_m_d;
            vector_q       <= vector_d;
            halted_q       <= halted_d;
            halt_bug_q     <= halt_bug_d;
        end
    end

    assign bus.iack         = iack_q;
    assign bus.int_dispatch = int_dispatch_q;
    assign bus.disp_m       = disp_m_q;
    assign bus.vector       = vector_q;
    assign bus.halted       = halted_q;
    assign bus.halt_bug     = halt_bug_q;
    assign bus.ime          = ime_q;

endmodule

// File: tb/tb_sm83_int_ctl.sv
// Directed bench for sm83_int_ctl; M-cycles are four clocks with t4 on the last.
module tb_sm83_int_ctl;
    import sm83_pkg::*;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    sm83_int_ctl_if bus_if ();

    sm83_int_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mcycle();
        for (int i = 0; i < 4; i++) begin
            bus_if.t4 = (i == 3);
            @(posedge clk);
            #1;
        end
        bus_if.t4 = 1'b0;
    endtask

    task automatic instr(input logic ei, input logic di, input logic reti, input logic halt);
        bus_if.instr_end = 1'b1;
        bus_if.ctl_ei    = ei;
        bus_if.ctl_di    = di;
        bus_if.ctl_reti  = reti;
        bus_if.ctl_halt  = halt;
        mcycle();
        bus_if.instr_end = 1'b0;
        bus_if.ctl_ei    = 1'b0;
        bus_if.ctl_di    = 1'b0;
        bus_if.ctl_reti  = 1'b0;
        bus_if.ctl_halt  = 1'b0;
    endtask

    // Completes a dispatch that has just entered cycle 0.
    task automatic dispatch_rest(input logic [7:0] sample_irq, input logic [7:0] exp_vec,
                                 input logic [7:0] exp_iack);
        mcycle();
        mcycle();
        bus_if.irq = sample_irq;
        mcycle();
        chk("dr_disp_m3", bus_if.disp_m, 8'd3);
        chk("dr_iack",    bus_if.iack, exp_iack);
        chk("dr_vector",  bus_if.vector, exp_vec);
        mcycle();
        chk("dr_iack_off", bus_if.iack, 8'h00);
        mcycle();
        chk("dr_done", bus_if.int_dispatch, 8'd0);
        chk("dr_vec_hold", bus_if.vector, exp_vec);
        bus_if.irq = 8'h00;
    endtask

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        reset            = 1'b1;
        bus_if.t4        = 1'b0;
        bus_if.irq       = 8'h00;
        bus_if.instr_end = 1'b0;
        bus_if.ctl_ei    = 1'b0;
        bus_if.ctl_di    = 1'b0;
        bus_if.ctl_reti  = 1'b0;
        bus_if.ctl_halt  = 1'b0;
        mcycle();
        mcycle();
        reset = 1'b0;
        chk("rst_ime",      bus_if.ime, 8'd0);
        chk("rst_iack",     bus_if.iack, 8'h00);
        chk("rst_disp",     bus_if.int_dispatch, 8'd0);
        chk("rst_disp_m",   bus_if.disp_m, 8'd0);
        chk("rst_vector",   bus_if.vector, 8'h00);
        chk("rst_halted",   bus_if.halted, 8'd0);
        chk("rst_halt_bug", bus_if.halt_bug, 8'd0);

        // Basic dispatch for irq 2, with control inputs ignored mid-dispatch.
        instr(1'b0, 1'b0, 1'b1, 1'b0);
        chk("reti_ime", bus_if.ime, 8'd1);
        bus_if.irq = 8'h04;
        instr(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_disp",   bus_if.int_dispatch, 8'd1);
        chk("t1_m0",     bus_if.disp_m, 8'd0);
        chk("t1_ime0",   bus_if.ime, 8'd0);
        instr(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_m1",     bus_if.disp_m, 8'd1);
        chk("t1_ignore", bus_if.ime, 8'd0);
        mcycle();
        chk("t1_m2",     bus_if.disp_m, 8'd2);
        chk("t1_iack_m2", bus_if.iack, 8'h00);
        mcycle();
        chk("t1_m3",     bus_if.disp_m, 8'd3);
        chk("t1_iack",   bus_if.iack, 8'h04);
        chk("t1_vec",    bus_if.vector, 8'h50);
        mcycle();
        chk("t1_m4",     bus_if.disp_m, 8'd4);
        chk("t1_iack_m4", bus_if.iack, 8'h00);
        mcycle();
        chk("t1_end",    bus_if.int_dispatch, 8'd0);
        chk("t1_m_end",  bus_if.disp_m, 8'd0);
        chk("t1_ime_end", bus_if.ime, 8'd0);
        bus_if.irq = 8'h00;

        // EI delay: the instruction after EI completes before dispatch.
        bus_if.irq = 8'h01;
        instr(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ei_nodisp", bus_if.int_dispatch, 8'd0);
        instr(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ei_disp",   bus_if.int_dispatch, 8'd1);
        dispatch_rest(8'h01, 8'h40, 8'h01);

        // Priority at the sample, then request withdrawn before the sample.
        bus_if.irq = 8'h03;
        instr(1'b0, 1'b0, 1'b1, 1'b0);
        chk("prio_disp", bus_if.int_dispatch, 8'd1);
        dispatch_rest(8'h03, 8'h40, 8'h01);
        bus_if.irq = 8'h01;
        instr(1'b0, 1'b0, 1'b1, 1'b0);
        dispatch_rest(8'h00, 8'h00, 8'h00);

        // HALT with ime=0 wakes to RUN; with ime=1 wakes into dispatch.
        instr(1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt_on",   bus_if.halted, 8'd1);
        mcycle();
        chk("halt_stay", bus_if.halted, 8'd1);
        bus_if.irq = 8'h10;
        mcycle();
        chk("halt_wake", bus_if.halted, 8'd0);
        chk("halt_nodisp", bus_if.int_dispatch, 8'd0);
        bus_if.irq = 8'h00;
        instr(1'b0, 1'b0, 1'b1, 1'b0);
        instr(1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt2_on",  bus_if.halted, 8'd1);
        chk("halt2_ime", bus_if.ime, 8'd1);
        bus_if.irq = 8'h10;
        mcycle();
        chk("halt2_wake", bus_if.halted, 8'd0);
        chk("halt2_disp", bus_if.int_dispatch, 8'd1);
        chk("halt2_ime0", bus_if.ime, 8'd0);
        dispatch_rest(8'h10, 8'h60, 8'h10);

        // HALT bug: pending request with ime=0.
        bus_if.irq = 8'h02;
        instr(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hb_on",     bus_if.halt_bug, 8'd1);
        chk("hb_nohalt", bus_if.halted, 8'd0);
        mcycle();
        chk("hb_off",    bus_if.halt_bug, 8'd0);
        chk("hb_run",    bus_if.halted, 8'd0);
        bus_if.irq = 8'h00;

        // Reset in the middle of a dispatch.
        bus_if.irq = 8'h01;
        instr(1'b0, 1'b0, 1'b1, 1'b0);
        mcycle();
        mcycle();
        mcycle();
        chk("rd_m3",   bus_if.disp_m, 8'd3);
        chk("rd_iack", bus_if.iack, 8'h01);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_if.irq = 8'h00;
        chk("rd_iack0", bus_if.iack, 8'h00);
        chk("rd_disp0", bus_if.int_dispatch, 8'd0);
        chk("rd_ime0",  bus_if.ime, 8'd0);
        chk("rd_m0",    bus_if.disp_m, 8'd0);

        // Non-t4 edge does nothing, then DI beats a pending request.
        instr(1'b0, 1'b0, 1'b1, 1'b0);
        bus_if.irq       = 8'h01;
        bus_if.instr_end = 1'b1;
        bus_if.t4        = 1'b0;
        @(posedge clk);
        #1;
        bus_if.instr_end = 1'b0;
        chk("not4_nodisp", bus_if.int_dispatch, 8'd0);
        chk("not4_ime",    bus_if.ime, 8'd1);
        instr(1'b0, 1'b1, 1'b0, 1'b0);
        chk("di_nodisp", bus_if.int_dispatch, 8'd0);
        chk("di_ime0",   bus_if.ime, 8'd0);

        // DI together with EI: DI wins, nothing is pended.
        instr(1'b1, 1'b1, 1'b0, 1'b0);
        instr(1'b0, 1'b0, 1'b0, 1'b0);
        chk("diei_nodisp", bus_if.int_dispatch, 8'd0);
        chk("diei_ime0",   bus_if.ime, 8'd0);
        bus_if.irq = 8'h00;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
